// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter with a registered serial output.
// Pops happen in IDLE or at the end of STOP, so back-to-back frames leave no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          overflow,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH    = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [15:0]   baud, baud_n;
  logic          tx_n, push, pop, bit_done;

  assign full     = (count == DEPTH);
  // Acceptance is judged on pre-edge occupancy, so a write while full is dropped even if a pop coincides.
  assign push     = wr_en && !full;
  assign bit_done = (baud == BAUD_MAX);
  assign busy     = (state != IDLE) || (count != '0);

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_idx_n = bit_idx;
    baud_n    = bit_done ? '0 : baud + 16'd1;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          tx_n      = shreg[0];
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shreg_n   = {1'b0, shreg[7:1]};
            tx_n      = shreg[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (count != '0) begin
            pop     = 1'b1;
            shreg_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
      baud     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      shreg    <= shreg_n;
      bit_idx  <= bit_idx_n;
      baud     <= baud_n;
      overflow <= wr_en && full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLKS_PER_BIT=10, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset, wr_en;
  logic [7:0] wr_data;
  logic       full, overflow, tx, busy;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .overflow(overflow), .tx(tx), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cyc(3);
    wr_data = 8'h12; wr_en = 1'b1;
    cyc(1);
    wr_en = 1'b0;
    cyc(3);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL pre_reset_tx: got %b want 0", tx); end
    #2 reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    @(negedge clk);
    reset = 1'b0; wr_data = 8'h77; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL first_edge_write: count %0d want 1", count); end
    cyc(110);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_frame;
    logic [9:0] f;
    f = {1'b1, 8'hAA, 1'b0};
    wr_data = 8'hAA; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; wr_data = 8'h00;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_latency_tx: got %b want 1", tx); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
    for (int t = 0; t < 10 * CPB; t++) begin
      @(negedge clk);
      checks++; if (tx !== f[t / CPB]) begin errors++; $display("FAIL single_tx t=%0d: got %b want %b", t, tx, f[t / CPB]); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b want 0", busy); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_idle_tx: got %b want 1", tx); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b [4];
    logic [2:0] cexp [4];
    logic [9:0] f;
    b    = '{8'hAA, 8'hCC, 8'hF0, 8'h55};
    cexp = '{3'd1, 3'd1, 3'd2, 3'd3};
    for (int i = 0; i < 4; i++) begin
      wr_data = b[i]; wr_en = 1'b1;
      @(negedge clk);
      checks++; if (count !== cexp[i]) begin errors++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, count, cexp[i]); end
      if (i > 0) begin
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start t=%0d: got %b want 0", i - 1, tx); end
      end
    end
    wr_en = 1'b0;
    for (int t = 3; t < 400; t++) begin
      @(negedge clk);
      f = {1'b1, b[t / 100], 1'b0};
      checks++; if (tx !== f[(t % 100) / CPB]) begin errors++; $display("FAIL b2b_tx t=%0d: got %b want %b", t, tx, f[(t % 100) / CPB]); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_stop: got %b want 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_overflow;
    logic [9:0] f;
    wr_data = 8'h81; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      wr_data = 8'h10 + 8'(i); wr_en = 1'b1;
      @(negedge clk);
      checks++; if (count !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin errors++; $display("FAIL ovf_count[%0d]: got %0d", i, count); end
      checks++; if (full !== (i >= 3)) begin errors++; $display("FAIL ovf_full[%0d]: got %b", i, full); end
      checks++; if (overflow !== (i == 4)) begin errors++; $display("FAIL ovf_pulse[%0d]: got %b", i, overflow); end
    end
    wr_en = 1'b0;
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_pulse_end: got %b want 0", overflow); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count_hold: got %0d want 4", count); end
    cyc(93);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL ovf_stop_tx: got %b want 1", tx); end
    wr_data = 8'hEE; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL popfull_count: got %0d want 3", count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL popfull_overflow: got %b want 1", overflow); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL popfull_full: got %b want 0", full); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL popfull_start: got %b want 0", tx); end
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL popfull_pulse_end: got %b want 0", overflow); end
    for (int t = 2; t < 400; t++) begin
      @(negedge clk);
      f = {1'b1, 8'h10 + 8'(t / 100), 1'b0};
      checks++; if (tx !== f[(t % 100) / CPB]) begin errors++; $display("FAIL ovf_order_tx t=%0d: got %b want %b", t, tx, f[(t % 100) / CPB]); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ovf_drain_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_frame;
    logic [9:0] f;
    wr_data = 8'hA5; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    wr_data = 8'h11; wr_en = 1'b1;
    @(negedge clk);
    wr_data = 8'h22;
    @(negedge clk);
    wr_en = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL mid_count: got %0d want 2", count); end
    cyc(52);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_bit4: got %b want 0", tx); end
    #2 reset = 1'b1;
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_reset_tx: got %b want 1", tx); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_reset_count: got %0d want 0", count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    f = {1'b1, 8'h3C, 1'b0};
    wr_data = 8'h3C; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    for (int t = 0; t < 10 * CPB; t++) begin
      @(negedge clk);
      checks++; if (tx !== f[t / CPB]) begin errors++; $display("FAIL post_reset_tx t=%0d: got %b want %b", t, tx, f[t / CPB]); end
    end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_loopback;
    logic [7:0] b [6];
    b = '{8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'h01};
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (i == 2) cyc(150);
          wr_data = b[i]; wr_en = 1'b1;
          @(negedge clk);
          wr_en = 1'b0;
        end
      end
      begin
        logic [7:0] d;
        bit         lost;
        lost = 1'b0;
        for (int k = 0; k < 6 && !lost; k++) begin
          int w;
          w = 0;
          while (tx !== 1'b0 && w < 3000) begin
            @(negedge clk);
            w++;
          end
          if (w >= 3000) begin
            checks++; errors++; lost = 1'b1;
            $display("FAIL rx_timeout byte %0d: no start bit within %0d cycles", k, w);
          end else begin
            cyc(4);
            checks++; if (tx !== 1'b0) begin errors++; $display("FAIL rx_start[%0d]: got %b want 0", k, tx); end
            for (int j = 0; j < 8; j++) begin
              cyc(CPB);
              d[j] = tx;
            end
            cyc(CPB);
            checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rx_framing[%0d]: stop %b want 1", k, tx); end
            checks++; if (d !== b[k]) begin errors++; $display("FAIL rx_byte[%0d]: got %h want %h", k, d, b[k]); end
          end
        end
      end
    join
    cyc(20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_busy_end: got %b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    cyc(2);
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_reset_mid_frame;
    test_loopback;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 5208, clock cycles per serial bit (9600 baud at 50 MHz, 104160 ns bit period); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, number of byte entries; power of two, 2..16.
REQ-003 Port clk  input  1  system clock, rising-edge active.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port wr_en  input  1  write strobe; byte on wr_data offered when high at a rising edge.
REQ-006 Port wr_data  input  8  byte to transmit.
REQ-007 Port full  output  1  high when FIFO holds FIFO_DEPTH entries.
REQ-008 Port overflow  output  1  one-cycle pulse when a write is dropped.
REQ-009 Port tx  output  1  serial line, idle high, registered.
REQ-010 Port busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-011 Port count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, data bits LSB first, stop bit 1; each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-014 IDLE: tx=1; if count>0, pop head byte into shift register, drive tx=0, go to START on the same edge.
REQ-015 START -> DATA after CLKS_PER_BIT cycles; DATA shifts one bit per CLKS_PER_BIT cycles, 3-bit bit index 0..7.
REQ-016 DATA -> STOP after bit 7 completes; STOP holds tx=1 for CLKS_PER_BIT cycles.
REQ-017 At STOP end: if count>0, pop and go directly to START with tx=0 (no idle gap); else go to IDLE.
REQ-018 Latency: write sampled at edge N into an empty FIFO with FSM in IDLE makes tx fall at edge N+1.
REQ-019 Write accepted only when count<FIFO_DEPTH; a write while full is dropped even if a pop occurs on the same edge, and overflow pulses for one cycle.
REQ-020 Simultaneous accepted write and pop SHALL leave count unchanged; stored order SHALL remain FIFO.
REQ-021 Read/write pointers SHALL wrap modulo FIFO_DEPTH; full = (count==FIFO_DEPTH).
REQ-022 Baud counter SHALL be 16 bits, counting 0..CLKS_PER_BIT-1, reset to 0 on every bit boundary.
REQ-023 busy = (state!=IDLE) or (count>0).
REQ-024 wr_data SHALL be captured at the accepting edge; later changes do not affect the queued byte.

Reset
REQ-025 reset high SHALL immediately, without a clock edge, force state=IDLE, tx=1, count=0, pointers=0, full=0, overflow=0, busy=0, counters=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame and discard all queued bytes; tx returns high at once.
REQ-027 After reset deasserts, the first rising edge SHALL be able to accept a write.
REQ-028 FIFO storage contents need not be reset.

Verification (CLKS_PER_BIT=10 for sim)
REQ-029 Write 0xAA once into idle block -> tx falls 1 edge later; line sequence 0,0,1,0,1,0,1,0,1,1, each 10 cycles; busy low after 100 cycles.
REQ-030 Write 0xAA, 0xCC, 0xF0, 0x55 on four consecutive cycles -> four frames back-to-back, 400 cycles of activity, no idle-high gap between stop and next start; count peaks at 3.
REQ-031 With FSM busy, write 5 bytes into the empty FIFO -> the first 4 accepted, full=1, 5th dropped with a single overflow pulse; count=4.
REQ-032 Write while full on the same edge as a STOP-end pop -> write dropped, overflow pulses, count becomes 3.
REQ-033 Assert reset during DATA bit 4 of 0xA5 with 2 bytes queued -> tx=1 immediately, count=0, busy=0; subsequent write 0x3C transmits correctly.
REQ-034 Loopback: drive tx into a reference UART receiver model -> every received byte equals the written byte in order; no framing errors.
